// File: rtl/clk_phase_tracker_if.sv
// clk_phase_tracker_if
//   Bundle between the CPU phase-clock generator and the phase tracker.
//   master : drives CLK_FETCH / CLK_ALU and observes the tracker status.
//   slave  : the tracker; samples the phase clocks and drives the status.
//   Signals:
//     CLK_FETCH, CLK_ALU : phase clocks (change on CLOCK negedge)
//     PHASE              : reconstructed 3-bit machine phase
//     LOCKED             : tracker is locked to the 8-cycle pattern
//     FETCH_START        : one-cycle pulse at accepted phase 3 in lock
//     ERR                : one-cycle pulse on a pattern mismatch
//     ERR_CNT            : saturating error count
//     INSTR_CNT          : wrapping fetch-start count
interface clk_phase_tracker_if #(
  parameter int ERR_W = 4,
  parameter int CNT_W = 16
);
  logic             CLK_FETCH;
  logic             CLK_ALU;
  logic [2:0]       PHASE;
  logic             LOCKED;
  logic             FETCH_START;
  logic             ERR;
  logic [ERR_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] INSTR_CNT;

  modport master (
    output CLK_FETCH, CLK_ALU,
    input  PHASE, LOCKED, FETCH_START, ERR, ERR_CNT, INSTR_CNT
  );

  modport slave (
    input  CLK_FETCH, CLK_ALU,
    output PHASE, LOCKED, FETCH_START, ERR, ERR_CNT, INSTR_CNT
  );
endinterface

// File: rtl/clk_phase_tracker.sv
// clk_phase_tracker
//   Receiving end of the CPU phase-clock interface. Samples CLK_FETCH and
//   CLK_ALU on every CLOCK posedge, reconstructs the 8-cycle machine phase,
//   reports lock, fetch-start pulses and an instruction count, and flags any
//   departure from the legal phase pattern.
//   Ports:
//     CLOCK : system clock, all state changes on posedge
//     RESET : synchronous, active-high reset
//     bus   : clk_phase_tracker_if.slave (phase clocks in, status out)
//
//   Legal (FETCH,ALU) pattern: p0=(0,1) p1,p2=(0,0) p3..p6=(1,0) p7=(0,0)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   HUNT  | waiting for an ALU rising edge with FETCH low (frame start)
//   SYNC  | following the pattern, counting clean frames toward lock
//   LOCK  | locked; emits FETCH_START at phase 3 and counts instructions
module clk_phase_tracker #(
  parameter int LOCK_FRAMES = 1,
  parameter int ERR_W       = 4,
  parameter int CNT_W       = 16
) (
  input logic              CLOCK,
  input logic              RESET,
  clk_phase_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0]       LAST_FRAME = 4'(LOCK_FRAMES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t           state;
  logic [2:0]       phase_q;
  logic             locked_q;
  logic             fetch_start_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             prev_alu;
  logic [3:0]       frame_cnt;

  logic [2:0] exp_phase;
  logic       exp_fetch;
  logic       exp_alu;
  logic       match;
  logic       start;

  always_comb begin
    exp_phase = phase_q + 3'd1;
    exp_fetch = (exp_phase >= 3'd3) && (exp_phase <= 3'd6);
    exp_alu   = (exp_phase == 3'd0);
    match     = (bus.CLK_FETCH == exp_fetch) && (bus.CLK_ALU == exp_alu);
    start     = bus.CLK_ALU && !prev_alu && !bus.CLK_FETCH;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state         <= HUNT;
      phase_q       <= 3'd0;
      locked_q      <= 1'b0;
      fetch_start_q <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      instr_cnt_q   <= '0;
      prev_alu      <= 1'b0;
      frame_cnt     <= 4'd0;
    end else begin
      prev_alu      <= bus.CLK_ALU;
      fetch_start_q <= 1'b0;
      err_q         <= 1'b0;
      case (state)
        HUNT: begin
          phase_q  <= 3'd0;
          locked_q <= 1'b0;
          if (start) begin
            frame_cnt <= 4'd0;
            state     <= SYNC;
          end
        end
        SYNC, LOCK: begin
          if (match) begin
            phase_q <= exp_phase;
            if (state == SYNC && exp_phase == 3'd7) begin
              if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= 4'd0;
                locked_q  <= 1'b1;
                state     <= LOCK;
              end else begin
                frame_cnt <= frame_cnt + 4'd1;
              end
            end
            if (state == LOCK && exp_phase == 3'd3) begin
              fetch_start_q <= 1'b1;
              instr_cnt_q   <= instr_cnt_q + 1'b1;
            end
          end else begin
            err_q     <= 1'b1;
            locked_q  <= 1'b0;
            frame_cnt <= 4'd0;
            phase_q   <= 3'd0;
            if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
            // A mismatching sample that is itself a frame start realigns
            // straight into SYNC instead of waiting another frame in HUNT.
            state <= start ? SYNC : HUNT;
          end
        end
        default: begin
          state     <= HUNT;
          phase_q   <= 3'd0;
          locked_q  <= 1'b0;
          frame_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.PHASE       = phase_q;
  assign bus.LOCKED      = locked_q;
  assign bus.FETCH_START = fetch_start_q;
  assign bus.ERR         = err_q;
  assign bus.ERR_CNT     = err_cnt_q;
  assign bus.INSTR_CNT   = instr_cnt_q;

endmodule

// File: tb/tb_clk_phase_tracker.sv
// tb_clk_phase_tracker
//   Directed bench for clk_phase_tracker. u0 uses LOCK_FRAMES=1, u1 uses
//   LOCK_FRAMES=2; both see the same phase clocks and reset.
module tb_clk_phase_tracker;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic fetch = 1'b0;
  logic alu   = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLOCK = ~CLOCK;

  clk_phase_tracker_if #(.ERR_W(4), .CNT_W(16)) ifc0 ();
  clk_phase_tracker_if #(.ERR_W(4), .CNT_W(16)) ifc1 ();

  assign ifc0.CLK_FETCH = fetch;
  assign ifc0.CLK_ALU   = alu;
  assign ifc1.CLK_FETCH = fetch;
  assign ifc1.CLK_ALU   = alu;

  clk_phase_tracker #(.LOCK_FRAMES(1), .ERR_W(4), .CNT_W(16)) u0 (
    .CLOCK(CLOCK), .RESET(RESET), .bus(ifc0.slave));
  clk_phase_tracker #(.LOCK_FRAMES(2), .ERR_W(4), .CNT_W(16)) u1 (
    .CLOCK(CLOCK), .RESET(RESET), .bus(ifc1.slave));

  typedef struct {
    logic        f, a, r;
    logic [2:0]  ph;
    logic        lk, fs, er;
    logic [3:0]  ec;
    logic [15:0] ic;
  } vec_t;

  vec_t tbl[$];

  function automatic logic pat_f(input int p);
    return (p >= 3 && p <= 6);
  endfunction

  function automatic logic pat_a(input int p);
    return (p == 0);
  endfunction

  function automatic void add(input logic f, a, r, input int ph,
                              input logic lk, fs, er, input int ec, ic);
    vec_t v;
    v.f = f; v.a = a; v.r = r; v.ph = 3'(ph);
    v.lk = lk; v.fs = fs; v.er = er; v.ec = 4'(ec); v.ic = 16'(ic);
    tbl.push_back(v);
  endfunction

  // legal sample of phase p, expected PHASE=p and no error
  function automatic void add_p(input int p, input logic lk, fs,
                                input int ec, ic);
    add(pat_f(p), pat_a(p), 1'b0, p, lk, fs, 1'b0, ec, ic);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input int which, input string nm, input int ph,
                         input logic lk, fs, er, input int ec, ic);
    if (which == 0) begin
      chk({nm, ".PHASE"},       32'(ifc0.PHASE),       32'(ph));
      chk({nm, ".LOCKED"},      32'(ifc0.LOCKED),      32'(lk));
      chk({nm, ".FETCH_START"}, 32'(ifc0.FETCH_START), 32'(fs));
      chk({nm, ".ERR"},         32'(ifc0.ERR),         32'(er));
      chk({nm, ".ERR_CNT"},     32'(ifc0.ERR_CNT),     32'(ec));
      chk({nm, ".INSTR_CNT"},   32'(ifc0.INSTR_CNT),   32'(ic));
    end else begin
      chk({nm, ".u1.PHASE"},       32'(ifc1.PHASE),       32'(ph));
      chk({nm, ".u1.LOCKED"},      32'(ifc1.LOCKED),      32'(lk));
      chk({nm, ".u1.FETCH_START"}, 32'(ifc1.FETCH_START), 32'(fs));
      chk({nm, ".u1.ERR"},         32'(ifc1.ERR),         32'(er));
      chk({nm, ".u1.ERR_CNT"},     32'(ifc1.ERR_CNT),     32'(ec));
      chk({nm, ".u1.INSTR_CNT"},   32'(ifc1.INSTR_CNT),   32'(ic));
    end
  endtask

  // inputs change on negedge; outputs sampled 1 time unit after posedge
  task automatic step(input logic f, a, r);
    @(negedge CLOCK);
    fetch = f; alu = a; RESET = r;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic step_p(input int which, input string nm, input int p,
                        input logic lk, fs, input int ec, ic);
    step(pat_f(p), pat_a(p), 1'b0);
    chk_dut(which, nm, p, lk, fs, 1'b0, ec, ic);
  endtask

  initial begin
    int eic;
    int eec;

    // ---------------- table: lock, fault at p4, relock ----------------
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);           // reset
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);           // idle in HUNT
    for (int p = 0; p <= 6; p++) add_p(p, 0, 0, 0, 0);
    add_p(7, 1, 0, 0, 0);                     // lock at first p7
    for (int p = 0; p <= 7; p++) add_p(p, 1, p == 3, 0, (p >= 3) ? 1 : 0);
    for (int p = 0; p <= 3; p++) add_p(p, 1, p == 3, 0, (p >= 3) ? 2 : 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2);           // FETCH dropped at p4
    add(1, 0, 0, 0, 0, 0, 0, 1, 2);           // p5 in HUNT
    add(1, 0, 0, 0, 0, 0, 0, 1, 2);           // p6 in HUNT
    add(0, 0, 0, 0, 0, 0, 0, 1, 2);           // p7 in HUNT
    for (int p = 0; p <= 6; p++) add_p(p, 0, 0, 1, 2);
    add_p(7, 1, 0, 1, 2);
    for (int p = 0; p <= 3; p++) add_p(p, 1, p == 3, 1, (p >= 3) ? 3 : 2);

    foreach (tbl[i]) begin
      step(tbl[i].f, tbl[i].a, tbl[i].r);
      chk_dut(0, $sformatf("vec%0d", i), tbl[i].ph, tbl[i].lk, tbl[i].fs,
              tbl[i].er, tbl[i].ec, tbl[i].ic);
    end

    // ---------------- run to INSTR_CNT=5, then reset with a mismatch ----
    eic = 3;
    for (int k = 0; k < 16; k++) begin
      int p;
      p = (k + 4) % 8;
      if (p == 3) eic++;
      step_p(0, "run5", p, 1, p == 3, 1, eic);
    end
    step(0, 0, 1);                            // p4 expected, reset wins
    chk_dut(0, "rst_locked", 0, 0, 0, 0, 0, 0);
    for (int p = 4; p <= 7; p++) begin
      step(pat_f(p), pat_a(p), 1'b0);
      chk_dut(0, "post_rst_hunt", 0, 0, 0, 0, 0, 0);
    end
    for (int p = 0; p <= 6; p++) step_p(0, "relock", p, 0, 0, 0, 0);
    step_p(0, "relock", 7, 1, 0, 0, 0);
    for (int p = 0; p <= 3; p++) step_p(0, "relock_run", p, 1, p == 3, 0, (p == 3) ? 1 : 0);

    // ---------------- immediate realign: start pattern at exp=4 ---------
    step(0, 1, 0);
    chk_dut(0, "realign_err", 0, 0, 0, 1, 1, 1);
    for (int p = 1; p <= 6; p++) step_p(0, "realign_sync", p, 0, 0, 1, 1);
    step_p(0, "realign_lock", 7, 1, 0, 1, 1);

    // ---------------- 20 faults, each after relock --------------------
    eec = 1;
    for (int i = 0; i < 20; i++) begin
      if (eec < 15) eec++;
      step(0, 0, 0);                          // p0 with ALU missing
      chk_dut(0, $sformatf("sat_err%0d", i), 0, 0, 0, 1, eec, 1);
      for (int p = 0; p <= 6; p++) begin
        step(pat_f(p), pat_a(p), 1'b0);
        chk(  $sformatf("sat_phase%0d", i), 32'(ifc0.PHASE), 32'(p));
      end
      step(pat_f(7), pat_a(7), 1'b0);
      chk($sformatf("sat_lock%0d", i), 32'(ifc0.LOCKED), 32'd1);
    end
    chk_dut(0, "sat_final", 7, 1, 0, 0, 15, 1);

    // ---------------- idle inputs for 100 clocks ----------------------
    step(0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      chk_dut(0, "idle", 0, 0, 0, 0, 0, 0);
    end
    step(1, 1, 0);
    chk_dut(0, "hunt_11", 0, 0, 0, 0, 0, 0);
    step(1, 0, 0);
    chk_dut(0, "hunt_10", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0);
    chk_dut(0, "hunt_00", 0, 0, 0, 0, 0, 0);

    // ---------------- stretched ALU, LOCK_FRAMES=2 on u1 --------------
    step(0, 0, 1);
    chk_dut(1, "str_rst", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0);
    chk_dut(1, "str_start", 0, 0, 0, 0, 0, 0);
    step(0, 1, 0);                            // ALU still high at p1
    chk_dut(1, "str_err", 0, 0, 0, 1, 1, 0);
    for (int p = 2; p <= 7; p++) begin
      step(pat_f(p), pat_a(p), 1'b0);
      chk_dut(1, "str_hunt", 0, 0, 0, 0, 1, 0);
    end
    for (int p = 0; p <= 7; p++) step_p(1, "str_frame1", p, 0, 0, 1, 0);
    chk("lf1_locked_cmp", 32'(ifc0.LOCKED), 32'd1);
    for (int p = 0; p <= 6; p++) step_p(1, "str_frame2", p, 0, 0, 1, 0);
    step_p(1, "str_lock", 7, 1, 0, 1, 0);
    for (int p = 0; p <= 3; p++) step_p(1, "str_run", p, 1, p == 3, 1, (p == 3) ? 1 : 0);
    step_p(1, "str_fs_clear", 4, 1, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
